// File: rtl/attr_interp_pkg.sv
// Shared widths, types and arithmetic helpers for the barycentric attribute interpolator.
package attr_interp_pkg;

    localparam int unsigned TID_W     = 16;
    localparam int unsigned LAM_W     = 32;
    localparam int unsigned FRAC      = 16;
    localparam int unsigned ATTR_W    = 16;
    localparam int unsigned N_ATTR    = 3;
    localparam int unsigned TBL_DEPTH = 16;
    localparam int unsigned IDX_W     = $clog2(TBL_DEPTH);
    localparam int unsigned Z_W       = 32;
    localparam int unsigned LAMX_W    = LAM_W + 2;
    localparam int unsigned PROD_W    = ATTR_W + 1 + LAMX_W;
    localparam int unsigned SUM_W     = PROD_W + 2;
    localparam int unsigned ROW_W     = 3 * N_ATTR * ATTR_W;
    localparam int unsigned OUT_W     = N_ATTR * ATTR_W;

    typedef logic        [ATTR_W-1:0] attr_t;
    typedef logic signed [LAM_W-1:0]  lam_t;
    typedef logic signed [LAMX_W-1:0] lamx_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [SUM_W-1:0]  sum_t;

    localparam lam_t LAM_ONE = lam_t'(1 << FRAC);

    // Vertex attribute row; v2 sits in the MSBs so cfg_data maps straight onto it.
    typedef struct packed {
        attr_t [N_ATTR-1:0] v2;
        attr_t [N_ATTR-1:0] v1;
        attr_t [N_ATTR-1:0] v0;
    } tri_attr_t;

    // Unsigned attribute times signed lambda, both widened before the multiply.
    function automatic prod_t attr_mul(input attr_t a, input lamx_t l);
        prod_t ax;
        prod_t lx;
        ax = prod_t'($signed({1'b0, a}));
        lx = prod_t'(l);
        return ax * lx;
    endfunction

    // Saturate a shifted sum into the unsigned attribute range.
    function automatic attr_t sat_attr(input sum_t x);
        if (x[SUM_W-1]) begin
            return '0;
        end else if (|x[SUM_W-2:ATTR_W]) begin
            return '1;
        end else begin
            return x[ATTR_W-1:0];
        end
    endfunction

endpackage

// File: rtl/attr_mac.sv
// One interpolated channel: registered products, then sum/shift/clamp into the output register.
// Rounding (half up) before the shift is enabled by defining ATTR_ROUND_EN; otherwise floor.
module attr_mac
    import attr_interp_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  attr_t a0,
    input  attr_t a1,
    input  attr_t a2,
    input  lamx_t l1,
    input  lamx_t l2,
    input  lamx_t l3,
    output attr_t attr
);

`ifdef ATTR_ROUND_EN
    localparam sum_t ROUND_K = sum_t'(1 << (FRAC - 1));
`else
    localparam sum_t ROUND_K = '0;
`endif

    prod_t p0_q;
    prod_t p1_q;
    prod_t p2_q;
    sum_t  sum_c;
    sum_t  shifted_c;

    // S2: three weighted products
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p0_q <= '0;
            p1_q <= '0;
            p2_q <= '0;
        end else if (en) begin
            p0_q <= attr_mul(a0, l1);
            p1_q <= attr_mul(a1, l2);
            p2_q <= attr_mul(a2, l3);
        end
    end

    always_comb begin
        sum_c     = sum_t'(p0_q) + sum_t'(p1_q) + sum_t'(p2_q) + ROUND_K;
        shifted_c = sum_c >>> FRAC;
    end

    // S3: clamped result straight into the output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            attr <= '0;
        end else if (en) begin
            attr <= sat_attr(shifted_c);
        end
    end

endmodule

// File: rtl/attr_interp.sv
// Barycentric attribute interpolator: 3-stage stallable pipeline behind lambdagen.
// Define ATTR_ROUND_EN for round-half-up results; default build truncates (floor).
module attr_interp
    import attr_interp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic             stall,
    input  logic [LAM_W-1:0] l1,
    input  logic [LAM_W-1:0] l2,
    input  logic [Z_W-1:0]   z_,
    input  logic [TID_W-1:0] tID,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [ROW_W-1:0] cfg_data,
    output logic [OUT_W-1:0] attr_o,
    output logic [Z_W-1:0]   z_o,
    output logic [TID_W-1:0] tID_o,
    output logic             dovalid
);

    tri_attr_t        tbl [TBL_DEPTH];
    logic             en_c;
    lamx_t            l1x_c;
    lamx_t            l2x_c;
    lamx_t            l3x_c;

    logic             s1_valid;
    lamx_t            s1_l1;
    lamx_t            s1_l2;
    lamx_t            s1_l3;
    logic [Z_W-1:0]   s1_z;
    logic [TID_W-1:0] s1_tid;
    tri_attr_t        s1_row;

    logic             s2_valid;
    logic [Z_W-1:0]   s2_z;
    logic [TID_W-1:0] s2_tid;

    always_comb begin
        en_c  = !stall;
        l1x_c = lamx_t'($signed(l1));
        l2x_c = lamx_t'($signed(l2));
        l3x_c = lamx_t'(LAM_ONE) - l1x_c - l2x_c;
    end

    // Table writes ignore stall; S1 sees the pre-edge row on a same-index write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < TBL_DEPTH; i++) begin
                tbl[i] <= '0;
            end
        end else if (cfg_we) begin
            tbl[cfg_addr] <= tri_attr_t'(cfg_data);
        end
    end

    // Stage valid bits and sideband; all frozen together while stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            dovalid  <= 1'b0;
            s1_z     <= '0;
            s1_tid   <= '0;
            s2_z     <= '0;
            s2_tid   <= '0;
            z_o      <= '0;
            tID_o    <= '0;
        end else if (en_c) begin
            s1_valid <= valid;
            s2_valid <= s1_valid;
            dovalid  <= s2_valid;
            s1_z     <= z_;
            s1_tid   <= tID;
            s2_z     <= s1_z;
            s2_tid   <= s1_tid;
            z_o      <= s2_z;
            tID_o    <= s2_tid;
        end
    end

    // S1 lambda/row capture; upper tID bits do not take part in the lookup
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_l1  <= '0;
            s1_l2  <= '0;
            s1_l3  <= '0;
            s1_row <= '0;
        end else if (en_c) begin
            s1_l1  <= l1x_c;
            s1_l2  <= l2x_c;
            s1_l3  <= l3x_c;
            s1_row <= tbl[tID[IDX_W-1:0]];
        end
    end

    for (genvar g = 0; g < N_ATTR; g++) begin : g_ch
        attr_mac u_mac (
            .clk  (clk),
            .rst  (rst),
            .en   (en_c),
            .a0   (s1_row.v0[g]),
            .a1   (s1_row.v1[g]),
            .a2   (s1_row.v2[g]),
            .l1   (s1_l1),
            .l2   (s1_l2),
            .l3   (s1_l3),
            .attr (attr_o[g*ATTR_W +: ATTR_W])
        );
    end

endmodule

// File: tb/tb_attr_interp.sv
// Self-checking bench for attr_interp: directed vectors, stall/reset sequences, random traffic vs model.
module tb_attr_interp;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid;
    logic         stall;
    logic [31:0]  l1;
    logic [31:0]  l2;
    logic [31:0]  z_;
    logic [15:0]  tID;
    logic         cfg_we;
    logic [3:0]   cfg_addr;
    logic [143:0] cfg_data;
    logic [47:0]  attr_o;
    logic [31:0]  z_o;
    logic [15:0]  tID_o;
    logic         dovalid;

    attr_interp dut (
        .clk      (clk),
        .rst      (rst),
        .valid    (valid),
        .stall    (stall),
        .l1       (l1),
        .l2       (l2),
        .z_       (z_),
        .tID      (tID),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .attr_o   (attr_o),
        .z_o      (z_o),
        .tID_o    (tID_o),
        .dovalid  (dovalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] tid;
        logic [31:0] l1;
        logic [31:0] l2;
        logic [31:0] z;
        logic [47:0] attr;
    } vec_t;

    typedef struct {
        logic [47:0] attr;
        logic [31:0] z;
        logic [15:0] tid;
    } exp_t;

    exp_t         exp_q[$];
    logic [15:0]  xfer_tid[$];
    logic [143:0] mtbl[16];
    int           errors = 0;
    int           checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference: weights as real-valued fixed point, floor (or round half up) then saturate.
    function automatic logic [47:0] model(input logic [143:0] row, input logic [31:0] a, input logic [31:0] b);
        longint la, lb, lc, s, q;
        logic [47:0] r;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        lc = 65536 - la - lb;
        r  = '0;
        for (int ch = 0; ch < 3; ch++) begin
            s = longint'(row[ch*16 +: 16]) * la
              + longint'(row[48 + ch*16 +: 16]) * lb
              + longint'(row[96 + ch*16 +: 16]) * lc;
`ifdef ATTR_ROUND_EN
            s = s + 32768;
`endif
            q = s >>> 16;
            if (q < 0) q = 0;
            if (q > 65535) q = 65535;
            r[ch*16 +: 16] = 16'(q);
        end
        return r;
    endfunction

    function automatic logic [143:0] rand_row();
        logic [159:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return w[143:0];
    endfunction

    task automatic idle();
        valid  = 1'b0;
        stall  = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic offer_exp(input logic [15:0] t, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] z, input logic [47:0] e);
        exp_t x;
        valid = 1'b1;
        tID   = t;
        l1    = a;
        l2    = b;
        z_    = z;
        if (!stall) begin
            x.attr = e;
            x.z    = z;
            x.tid  = t;
            exp_q.push_back(x);
        end
    endtask

    task automatic offer(input logic [15:0] t, input logic [31:0] a, input logic [31:0] b, input logic [31:0] z);
        offer_exp(t, a, b, z, model(mtbl[t[3:0]], a, b));
    endtask

    // One clock: score any output transfer, track table writes, verify hold under stall.
    task automatic cycle();
        logic [47:0] h_attr;
        logic [31:0] h_z;
        logic [15:0] h_tid;
        logic        h_v;
        logic        held;
        exp_t        e;
        if (dovalid && !stall) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out: got pixel tID_o 0x%0h, required no output", tID_o);
            end else begin
                e = exp_q.pop_front();
                check("attr_o", attr_o, e.attr);
                check("z_o", z_o, e.z);
                check("tID_o", tID_o, e.tid);
                xfer_tid.push_back(tID_o);
            end
        end
        if (cfg_we) mtbl[cfg_addr] = cfg_data;
        h_attr = attr_o;
        h_z    = z_o;
        h_tid  = tID_o;
        h_v    = dovalid;
        held   = stall;
        @(posedge clk);
        #1;
        if (held) begin
            check("hold_dovalid", dovalid, h_v);
            check("hold_attr_o", attr_o, h_attr);
            check("hold_z_o", z_o, h_z);
            check("hold_tID_o", tID_o, h_tid);
        end
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [143:0] d);
        idle();
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        cycle();
        cfg_we = 1'b0;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pixels outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        cycle();
    endtask

`ifdef ATTR_ROUND_EN
    localparam logic [47:0] EXP_V0 = {16'h8000, 16'h06D6, 16'h0071};
    localparam logic [47:0] EXP_V6 = {16'h0CD1, 16'h088C, 16'h0447};
`else
    localparam logic [47:0] EXP_V0 = {16'h7FFF, 16'h06D6, 16'h0070};
    localparam logic [47:0] EXP_V6 = {16'h0CD0, 16'h088B, 16'h0446};
`endif

    vec_t         vecs[7];
    logic [143:0] old_row;
    logic [143:0] new_row;
    int           p;

    initial begin
        vecs[0] = '{16'h0000, 32'h0000_8000, 32'h0000_4000, 32'h1234_5678, EXP_V0};
        vecs[1] = '{16'h0005, 32'h0001_0000, 32'h0000_0000, 32'hDEAD_BEEF, {16'h3333, 16'h2222, 16'h1111}};
        vecs[2] = '{16'h0015, 32'h0000_0000, 32'h0001_0000, 32'h0000_0000, {16'h0003, 16'h0002, 16'h0001}};
        vecs[3] = '{16'h1230, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, {16'h0000, 16'h0BB8, 16'h0032}};
        vecs[4] = '{16'h0001, 32'h0002_0000, 32'h0000_0000, 32'h0000_0001, {16'hFFFF, 16'h00C8, 16'hFFFF}};
        vecs[5] = '{16'h0001, 32'hFFFF_0000, 32'h0000_0000, 32'h0000_0002, {16'h0000, 16'h0000, 16'h0000}};
        vecs[6] = '{16'h0005, 32'h0000_4000, 32'h0000_4000, 32'hCAFE_0006, EXP_V6};
        foreach (mtbl[i]) mtbl[i] = '0;
        idle();
        l1 = '0; l2 = '0; z_ = '0; tID = '0; cfg_addr = '0; cfg_data = '0;

        // Power-on reset
        #1 rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_dovalid", dovalid, 1'b0);
        check("reset_attr_o", attr_o, 48'h0);
        check("reset_z_o", z_o, 32'h0);
        check("reset_tID_o", tID_o, 16'h0);
        rst = 1'b1;

        cfg_write(4'd0, {16'h0000, 16'd3000, 16'd50, 16'h0000, 16'd2000, 16'd200, 16'hFFFF, 16'd1000, 16'd100});
        cfg_write(4'd1, {16'h0000, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h8000, 16'd100, 16'hFFFF});
        cfg_write(4'd5, {16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'h3333, 16'h2222, 16'h1111});
        cycle();

        // Single pixel: dovalid exactly three cycles after valid
        offer_exp(vecs[0].tid, vecs[0].l1, vecs[0].l2, vecs[0].z, vecs[0].attr);
        cycle();
        idle();
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("latency_%0d", k), dovalid, 1'(k == 3));
            if (k < 3) cycle();
        end
        drain();

        // Directed vectors, back to back
        foreach (vecs[i]) begin
            offer_exp(vecs[i].tid, vecs[i].l1, vecs[i].l2, vecs[i].z, vecs[i].attr);
            cycle();
        end
        drain();

        // Five pixels with a two-cycle stall starting two cycles in
        cfg_write(4'd2, rand_row());
        cfg_write(4'd3, rand_row());
        cfg_write(4'd4, rand_row());
        xfer_tid.delete();
        p = 0;
        for (int c = 0; p < 5; c++) begin
            stall = (c == 2 || c == 3);
            offer(16'(p), 32'h0000_4000, 32'h0000_8000, 32'(p + 100));
            cycle();
            if (!(c == 2 || c == 3)) p++;
        end
        drain();
        check("stall_xfer_count", 64'(xfer_tid.size()), 64'd5);
        for (int i = 0; i < 5 && i < xfer_tid.size(); i++) check($sformatf("stall_order_%0d", i), xfer_tid[i], 16'(i));

        // Same-cycle table write and read of index 3: old row, then new row
        old_row = mtbl[3];
        new_row = rand_row();
        new_row[15:0] = ~old_row[15:0];
        cfg_we   = 1'b1;
        cfg_addr = 4'd3;
        cfg_data = new_row;
        offer_exp(16'h0003, 32'h0001_0000, 32'h0, 32'h0000_0333, old_row[47:0]);
        cycle();
        cfg_we = 1'b0;
        offer_exp(16'h0003, 32'h0001_0000, 32'h0, 32'h0000_0334, new_row[47:0]);
        cycle();
        drain();

        // Asynchronous reset with three pixels in flight
        for (int i = 0; i < 3; i++) begin
            offer(16'h0005, 32'h0000_4000, 32'h0000_4000, 32'(i + 7));
            cycle();
        end
        idle();
        #2 rst = 1'b0;
        #1;
        check("midreset_dovalid", dovalid, 1'b0);
        check("midreset_attr_o", attr_o, 48'h0);
        check("midreset_z_o", z_o, 32'h0);
        check("midreset_tID_o", tID_o, 16'h0);
        exp_q.delete();
        foreach (mtbl[i]) mtbl[i] = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("post_reset_dovalid", dovalid, 1'b0);
        end
        offer_exp(16'h0005, 32'h0001_0000, 32'h0, 32'h0000_0055, 48'h0);
        cycle();
        drain();

        // Random traffic against the reference model
        for (int i = 0; i < 16; i++) cfg_write(4'(i), rand_row());
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, b;
            idle();
            stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) begin
                cfg_we   = 1'b1;
                cfg_addr = 4'($urandom);
                cfg_data = rand_row();
            end
            if ($urandom_range(0, 1) == 0) begin
                a = $urandom_range(0, 65536);
                b = $urandom_range(0, 65536 - a);
            end else begin
                a = $urandom;
                b = $urandom;
            end
            if ($urandom_range(0, 4) != 0) offer(16'($urandom), a, b, $urandom);
            cycle();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
